// File: rtl/pipe_pkg.sv
// Shared defaults and control-bundle bit positions for the writeback pipe stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 2;

  // Control bundle bit indices
  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;

endpackage

// File: rtl/pipe_slot.sv
// One valid-tagged beat register with load and clear; clear wins over load.
// Latency: 1 cycle from load to registered fields.
// Backpressure: none itself; the parent decides when to load or clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] alu_d,
  input  logic [ADDR_W-1:0] rd_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] alu_q,
  output logic [ADDR_W-1:0] rd_q
);

  // Clearing zeros ctrl so an empty slot can never request a register write;
  // data and address keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
      mem_q  <= '0;
      alu_q  <= '0;
      rd_q   <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      ctrl_q <= ctrl_d;
      mem_q  <= mem_d;
      alu_q  <= alu_d;
      rd_q   <= rd_d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready register stage for MEM/WB beats; optional skid entry under PIPE_STAGE_HS_SKID_EN.
// Latency: 1 cycle from input transfer to out_valid_o.
// Backpressure: default build ready = !out_valid_o || out_ready_i; skid build ready = skid entry empty (registered).
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] memdata_i,
  input  logic [DATA_W-1:0] aluresult_i,
  input  logic [ADDR_W-1:0] rdaddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] memdata_o,
  output logic [DATA_W-1:0] aluresult_o,
  output logic [ADDR_W-1:0] rdaddr_o
);

  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_mem_d;
  logic [DATA_W-1:0] main_alu_d;
  logic [ADDR_W-1:0] main_rd_d;
  logic              in_xfer;

  assign in_xfer = in_valid_i && in_ready_o;

`ifdef PIPE_STAGE_HS_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_clear;
  logic              main_free;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_mem;
  logic [DATA_W-1:0] skid_alu;
  logic [ADDR_W-1:0] skid_rd;

  // Ready comes straight from the skid valid flop, so no combinational path to out_ready_i.
  assign in_ready_o = !skid_valid;
  assign main_free  = !main_valid || out_ready_i;

  // Main refills from skid first (older beat), otherwise from the input.
  always_comb begin
    main_ctrl_d = ctrl_i;
    main_mem_d  = memdata_i;
    main_alu_d  = aluresult_i;
    main_rd_d   = rdaddr_i;
    if (skid_valid) begin
      main_ctrl_d = skid_ctrl;
      main_mem_d  = skid_mem;
      main_alu_d  = skid_alu;
      main_rd_d   = skid_rd;
    end
  end

  assign main_load  = main_free && (skid_valid || in_xfer);
  assign main_clear = flush_i || (main_valid && out_ready_i && !skid_valid && !in_xfer);
  assign skid_load  = in_xfer && !main_free;
  assign skid_clear = flush_i || (skid_valid && main_free);

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (skid_load),
    .clear  (skid_clear),
    .ctrl_d (ctrl_i),
    .mem_d  (memdata_i),
    .alu_d  (aluresult_i),
    .rd_d   (rdaddr_i),
    .valid  (skid_valid),
    .ctrl_q (skid_ctrl),
    .mem_q  (skid_mem),
    .alu_q  (skid_alu),
    .rd_q   (skid_rd)
  );
`else
  // Single entry: accept when empty or when the held beat leaves this edge.
  assign in_ready_o  = !main_valid || out_ready_i;
  assign main_ctrl_d = ctrl_i;
  assign main_mem_d  = memdata_i;
  assign main_alu_d  = aluresult_i;
  assign main_rd_d   = rdaddr_i;
  assign main_load   = in_xfer;
  assign main_clear  = flush_i || (main_valid && out_ready_i && !in_xfer);
`endif

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (main_load),
    .clear  (main_clear),
    .ctrl_d (main_ctrl_d),
    .mem_d  (main_mem_d),
    .alu_d  (main_alu_d),
    .rd_d   (main_rd_d),
    .valid  (main_valid),
    .ctrl_q (ctrl_o),
    .mem_q  (memdata_o),
    .alu_q  (aluresult_o),
    .rd_q   (rdaddr_o)
  );

  assign out_valid_o = main_valid;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: randomized and directed beats against a queue model.
// Latency: expects each accepted beat at the head of the output one edge after acceptance.
// Backpressure: model ready is 1-entry or 2-entry depending on PIPE_STAGE_HS_SKID_EN.
module tb_pipe_stage_hs;

`ifdef PIPE_STAGE_HS_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ctrl;
  logic [31:0] mem;
  logic [31:0] alu;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  ctrl_o;
  logic [31:0] mem_o;
  logic [31:0] alu_o;
  logic [4:0]  rd_o;

  // Wide instance signals
  logic        v64;
  logic        rdy64;
  logic        fl64;
  logic        ordy64;
  logic [1:0]  ctrl64;
  logic [63:0] mem64;
  logic [63:0] alu64;
  logic [5:0]  rd64;
  logic        ov64;
  logic [1:0]  ctrl64_o;
  logic [63:0] mem64_o;
  logic [63:0] alu64_o;
  logic [5:0]  rd64_o;

  pipe_stage_hs dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ctrl_i(ctrl), .memdata_i(mem), .aluresult_i(alu), .rdaddr_i(rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ctrl_o(ctrl_o), .memdata_o(mem_o), .aluresult_o(alu_o), .rdaddr_o(rd_o)
  );

  pipe_stage_hs #(.DATA_W(64), .ADDR_W(6), .CTRL_W(2)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl64),
    .in_valid_i(v64), .in_ready_o(rdy64),
    .ctrl_i(ctrl64), .memdata_i(mem64), .aluresult_i(alu64), .rdaddr_i(rd64),
    .out_valid_o(ov64), .out_ready_i(ordy64),
    .ctrl_o(ctrl64_o), .memdata_o(mem64_o), .aluresult_o(alu64_o), .rdaddr_o(rd64_o)
  );

  typedef struct {
    logic [1:0]  c;
    logic [31:0] m;
    logic [31:0] a;
    logic [4:0]  r;
  } beat_t;

  beat_t exp_q[$];
  int    passed = 0;
  int    total  = 0;
  bit    run    = 1'b0;
  bit    drain  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: compare the presented beat with the scoreboard head, note a drain.
  always @(negedge clk) begin
    if (run) begin
      if (exp_q.size() > 0) begin
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("ctrl_o",    64'(ctrl_o),    64'(exp_q[0].c));
        chk("memdata_o", 64'(mem_o),     64'(exp_q[0].m));
        chk("alu_o",     64'(alu_o),     64'(exp_q[0].a));
        chk("rdaddr_o",  64'(rd_o),      64'(exp_q[0].r));
        drain = out_ready;
      end else begin
        chk("out_valid_idle", 64'(out_valid), 64'd0);
        chk("bubble_ctrl",    64'(ctrl_o),    64'd0);
        drain = 1'b0;
      end
    end else begin
      drain = 1'b0;
    end
  end

  // Monitor: retire the head on an output transfer.
  always @(posedge clk) begin
    if (drain && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // One driven cycle; entered and left at posedge+1.
  task automatic cycle(input bit v, input logic [1:0] c, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] m,
                       input bit ordy, input bit fl);
    bit    mready;
    bit    acc;
    beat_t b;
    in_valid  = v;
    ctrl      = c;
    rd        = r;
    alu       = a;
    mem       = m;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    mready = (CAP == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
    chk("in_ready", 64'(in_ready), 64'(mready));
    acc = v && mready;
    b.c = c; b.m = m; b.a = a; b.r = r;
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b11, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; ctrl = 2'b11;
    mem = 32'hDEAD_BEEF; alu = 32'h1234_5678; rd = 5'd7; out_ready = 1'b1;
    v64 = 1'b1; fl64 = 1'b0; ordy64 = 1'b1; ctrl64 = 2'b11;
    mem64 = 64'h1; alu64 = 64'h2; rd64 = 6'd3;

    // Reset held with a beat offered: everything zero
    #23;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ctrl",      64'(ctrl_o),    64'd0);
    chk("rst_mem",       64'(mem_o),     64'd0);
    chk("rst_alu",       64'(alu_o),     64'd0);
    chk("rst_rd",        64'(rd_o),      64'd0);
    chk("rst_valid64",   64'(ov64),      64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; v64 = 1'b0;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    run = 1'b1;

    // Wide instance carries the full 64-bit word
    v64 = 1'b1; mem64 = 64'hFFFF_FFFF_0000_0001;
    @(posedge clk);
    #1;
    v64 = 1'b0;
    chk("w64_valid", 64'(ov64),    64'd1);
    chk("w64_mem",   mem64_o,      64'hFFFF_FFFF_0000_0001);

    // Streaming 1..8
    for (int n = 1; n <= 8; n++)
      cycle(1'b1, 2'b10, 5'(n), 32'h100 + 32'(n), $urandom, 1'b1, 1'b0);
    idle(2);

    // Backpressure on rdaddr 5, offer 6 during the stall
    cycle(1'b1, 2'b11, 5'd5, 32'h55, 32'h505, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b11, 5'd6, 32'h66, 32'h606, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 5'd6, 32'h66, 32'h606, 1'b1, 1'b0);
    idle(3);

    // Flush with held beats and a same-edge arrival of rdaddr 9
    cycle(1'b1, 2'b11, 5'd7, 32'h77, 32'h707, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 5'd8, 32'h88, 32'h808, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 5'd9, 32'h99, 32'h909, 1'b1, 1'b1);
    idle(2);

    // Bubble with ctrl_i all ones
    cycle(1'b0, 2'b11, 5'd3, 32'h33, 32'h303, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 500; i++)
      cycle(($urandom % 4) != 0, 2'($urandom), 5'($urandom), $urandom, $urandom,
            ($urandom % 3) != 0, ($urandom % 25) == 0);
    idle(3);

    // Reset asserted with a beat held drops it
    cycle(1'b1, 2'b11, 5'd12, 32'hC0, 32'hC00, 1'b0, 1'b0);
    run = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ctrl",  64'(ctrl_o),    64'd0);
    chk("midrst_rd",    64'(rd_o),      64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b1;
    idle(2);
    cycle(1'b1, 2'b01, 5'd21, 32'h2121, 32'h1212, 1'b1, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of each data word (memory data, ALU result).
REQ-002 Parameter ADDR_W, default 5, SHALL set the destination register address width.
REQ-003 Parameter CTRL_W, default 2, SHALL set the control bundle width (bit0 MemtoReg, bit1 RegWrite).
REQ-004 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 flush_i  in  1  synchronous kill of all held beats.
REQ-007 in_valid_i  in  1  upstream beat present.
REQ-008 in_ready_o  out  1  stage can accept a beat.
REQ-009 ctrl_i  in  CTRL_W  control bundle.
REQ-010 memdata_i, aluresult_i  in  DATA_W each  data words.
REQ-011 rdaddr_i  in  ADDR_W  destination register.
REQ-012 out_valid_o  out  1  downstream beat present.
REQ-013 out_ready_i  in  1  downstream accepts.
REQ-014 ctrl_o, memdata_o, aluresult_o, rdaddr_o  out  CTRL_W/DATA_W/DATA_W/ADDR_W  registered beat fields.

Function
REQ-015 Input transfer SHALL occur iff in_valid_i && in_ready_o at a rising edge; output transfer iff out_valid_o && out_ready_i.
REQ-016 A beat accepted at edge N SHALL appear on outputs with out_valid_o=1 immediately after edge N (latency 1) when the stage was empty or draining.
REQ-017 Beats SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-018 While out_valid_o=1 and out_ready_i=0, all outputs SHALL hold stable.
REQ-019 ctrl_o SHALL be all-zero whenever out_valid_o=0 (bubble never writes a register); data/address outputs then hold last value.
REQ-020 Simultaneous input and output transfer on a single held beat SHALL replace it with the new beat, out_valid_o staying 1.
REQ-021 flush_i=1 at an edge SHALL invalidate every held beat, zero ctrl_o, and discard any beat transferred that same edge; flush SHALL take precedence over all transfers.
REQ-022 in_ready_o SHALL NOT depend on flush_i.

Reset
REQ-023 While rst_n_i=0: out_valid_o=0, ctrl_o=0, memdata_o=0, aluresult_o=0, rdaddr_o=0, all internal entries invalid.
REQ-024 First edge after rst_n_i deasserts SHALL see in_ready_o=1; reset asserted mid-transfer SHALL drop the beat.

Configuration
REQ-025 Macro PIPE_STAGE_HS_SKID_EN defined: two entries (main + skid); in_ready_o SHALL be a register output equal to "skid entry empty"; beat arriving while main held and not drained SHALL go to skid; skid SHALL move to main on the edge main drains; full throughput with no combinational ready path.
REQ-026 Macro undefined: single entry; in_ready_o SHALL equal !out_valid_o || out_ready_i (combinational).

Structure
REQ-027 Shared package pipe_pkg SHALL hold default DATA_W/ADDR_W/CTRL_W and control bit indices CTRL_MEMTOREG=0, CTRL_REGWRITE=1.
REQ-028 Sub-module pipe_slot (one valid-tagged entry with load/clear) SHALL be instantiated once, or twice under PIPE_STAGE_HS_SKID_EN.

Verification
REQ-029 Reset: hold rst_n_i=0 with in_valid_i=1 -> out_valid_o=0, ctrl_o=0, all outputs 0; after release in_ready_o=1.
REQ-030 Streaming: beats rdaddr 1..8, aluresult 0x100+n, out_ready_i=1 -> outputs 1..8 in order, one per cycle, first one edge after acceptance.
REQ-031 Backpressure: out_ready_i=0 for 3 cycles with beat rdaddr=5 held -> outputs stable; skid build accepts one more (rdaddr=6) then in_ready_o=0; release -> 5 then 6.
REQ-032 Flush: two beats held (skid build), flush_i=1 with in_valid_i=1 rdaddr=9 -> next cycle out_valid_o=0, ctrl_o=0, rdaddr 9 never appears.
REQ-033 Bubble: in_valid_i=0 with ctrl_i=2'b11 -> ctrl_o=2'b00, out_valid_o=0.
REQ-034 Width: DATA_W=64, ADDR_W=6, memdata_i=0xFFFF_FFFF_0000_0001 -> identical value on memdata_o.
